// File: rtl/return_addr_stack_pkg.sv
// return_addr_stack_pkg: shared widths for the return-address stack and the datapath
package return_addr_stack_pkg;
    localparam int PC_W      = 12;
    localparam int RAS_DEPTH = 8;
endpackage

// File: rtl/return_addr_stack_ptr_ctl.sv
// ras_ptr_ctl: top pointer, occupancy count, sticky error flags and entry write control
module ras_ptr_ctl
    import return_addr_stack_pkg::*;
#(
    parameter int DEPTH     = RAS_DEPTH,
    parameter bit OVERWRITE = 1'b1,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear_err,
    output logic [PW-1:0] top_ptr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    output logic          wr_en,
    output logic [PW-1:0] wr_addr
);
    logic adv;
    logic retreat;
    logic ovf_set;
    logic udf_set;

    // Classify the request: advance to a new top, retreat, or replace the current top in place
    always_comb begin
        empty   = count == '0;
        full    = count == CW'(DEPTH);
        adv     = push && (pop ? empty : (!full || OVERWRITE));
        retreat = pop && !push && !empty;
        wr_en   = adv || (push && pop && !empty);
        wr_addr = adv ? top_ptr + PW'(1) : top_ptr;
        ovf_set = push && !pop && full;
        udf_set = pop && empty;
    end

    // Pointer wraps naturally; a full-stack overwrite advances the pointer but keeps count at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr   <= PW'(DEPTH - 1);
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            top_ptr   <= adv ? top_ptr + PW'(1) : retreat ? top_ptr - PW'(1) : top_ptr;
            count     <= (adv && !full) ? count + CW'(1) : retreat ? count - CW'(1) : count;
            overflow  <= ovf_set || (overflow && !clear_err);
            underflow <= udf_set || (underflow && !clear_err);
        end
    end
endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular LIFO of return PCs with zero-latency top-of-stack output
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int WIDTH     = PC_W,
    parameter int DEPTH     = RAS_DEPTH,
    parameter bit OVERWRITE = 1'b1,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] stack_in,
    input  logic             clear_err,
    output logic [WIDTH-1:0] stack_out,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top_ptr;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;

    ras_ptr_ctl #(.DEPTH(DEPTH), .OVERWRITE(OVERWRITE)) ctl (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear_err (clear_err),
        .top_ptr   (top_ptr),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr)
    );

    // Entry storage is never cleared; reset only suppresses a concurrent write
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_addr] <= stack_in;
    end

    // Empty masks the uninitialised RAM so the next_pc mux never sees X
    always_comb begin
        stack_out = empty ? '0 : mem[top_ptr];
    end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: randomized and directed checks of both overflow policies against a queue model
module tb_return_addr_stack;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [11:0] stack_in = '0;
    logic        clear_err = 1'b0;
    logic [11:0] so  [2];
    logic        emp [2];
    logic        ful [2];
    logic [3:0]  cnt [2];
    logic        ovf [2];
    logic        udf [2];

    logic [11:0] mq [2][$];
    bit          mo [2];
    bit          mu [2];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    // index 0 drops pushes when full, index 1 overwrites the oldest entry
    return_addr_stack #(.WIDTH(12), .DEPTH(8), .OVERWRITE(1'b0)) dut_drop (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .stack_in(stack_in), .clear_err(clear_err),
        .stack_out(so[0]), .empty(emp[0]), .full(ful[0]), .count(cnt[0]), .overflow(ovf[0]), .underflow(udf[0])
    );
    return_addr_stack #(.WIDTH(12), .DEPTH(8), .OVERWRITE(1'b1)) dut_ow (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .stack_in(stack_in), .clear_err(clear_err),
        .stack_out(so[1]), .empty(emp[1]), .full(ful[1]), .count(cnt[1]), .overflow(ovf[1]), .underflow(udf[1])
    );

    function automatic logic [11:0] exp_top(input int k);
        return mq[k].size() == 0 ? 12'h000 : mq[k][mq[k].size() - 1];
    endfunction

    // Apply one cycle of inputs, let the edge happen, advance the reference model
    task automatic step(input bit rs, input bit ps, input bit pp, input logic [11:0] d, input bit ce);
        reset = rs; push = ps; pop = pp; stack_in = d; clear_err = ce;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit os;
            bit us;
            os = ps && !pp && mq[k].size() == 8;
            us = pp && mq[k].size() == 0;
            if (rs) begin
                mq[k].delete();
                mo[k] = 0;
                mu[k] = 0;
            end else begin
                if (ps && pp) begin
                    if (mq[k].size() != 0) mq[k][mq[k].size() - 1] = d;
                    else mq[k].push_back(d);
                end else if (ps) begin
                    if (mq[k].size() < 8) mq[k].push_back(d);
                    else if (k == 1) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(d);
                    end
                end else if (pp && mq[k].size() != 0) begin
                    void'(mq[k].pop_back());
                end
                mo[k] = os || (mo[k] && !ce);
                mu[k] = us || (mu[k] && !ce);
            end
        end
        #1;
        reset = 0; push = 0; pop = 0; clear_err = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 12'h000, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({cnt[k], emp[k], ful[k], ovf[k], udf[k], so[k]} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000}) begin
                miscompares++;
                $display("FAIL reset dut%0d: got cnt=%0d e=%b f=%b o=%b u=%b out=%h, want 0 1 0 0 0 000",
                         k, cnt[k], emp[k], ful[k], ovf[k], udf[k], so[k]);
            end
        end
    endtask

    task automatic test_push_pop();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 12'h010, 0);
        step(0, 1, 0, 12'h020, 0);
        step(0, 1, 0, 12'h030, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (cnt[k] !== 4'd3 || so[k] !== 12'h030) begin
                miscompares++;
                $display("FAIL push3 dut%0d: got cnt=%0d out=%h, want 3 030", k, cnt[k], so[k]);
            end
        end
        step(0, 0, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (cnt[k] !== 4'd2 || so[k] !== 12'h020) begin
                miscompares++;
                $display("FAIL pop1 dut%0d: got cnt=%0d out=%h, want 2 020", k, cnt[k], so[k]);
            end
        end
    endtask

    task automatic test_fill();
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++) step(0, 1, 0, 12'(i), 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (cnt[k] !== 4'd8 || ful[k] !== 1'b1 || ovf[k] !== 1'b1 || emp[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL fill dut%0d: got cnt=%0d f=%b o=%b e=%b, want 8 1 1 0", k, cnt[k], ful[k], ovf[k], emp[k]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            pop = 1;
            #1;
            for (int k = 0; k < 2; k++) begin
                logic [11:0] want;
                want = 12'((k == 1 ? 9 : 8) - i);
                vectors++;
                if (so[k] !== want) begin
                    miscompares++;
                    $display("FAIL drain%0d dut%0d: got %h want %h", i, k, so[k], want);
                end
            end
            step(0, 0, 1, 0, 0);
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (emp[k] !== 1'b1 || so[k] !== 12'h000 || cnt[k] !== 4'd0 || ovf[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL drained dut%0d: got e=%b out=%h cnt=%0d o=%b, want 1 000 0 1", k, emp[k], so[k], cnt[k], ovf[k]);
            end
        end
    endtask

    task automatic test_underflow();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        vectors++;
        if (udf[1] !== 1'b1 || cnt[1] !== 4'd0) begin
            miscompares++;
            $display("FAIL udf_set: got u=%b cnt=%0d, want 1 0", udf[1], cnt[1]);
        end
        step(0, 0, 1, 0, 1);
        vectors++;
        if (udf[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL udf_set_wins: got u=%b want 1", udf[1]);
        end
        step(0, 0, 0, 0, 1);
        vectors++;
        if (udf[1] !== 1'b0 || udf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL udf_clear: got u=%b/%b want 0/0", udf[0], udf[1]);
        end
    endtask

    task automatic test_back_to_back();
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 12'h100, 0);
        step(0, 1, 0, 12'h200, 0);
        step(0, 1, 1, 12'h2AA, 0);
        vectors++;
        if (cnt[1] !== 4'd2 || so[1] !== 12'h2AA || udf[1] !== 1'b0 || ovf[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL replace: got cnt=%0d out=%h o=%b u=%b, want 2 2aa 0 0", cnt[1], so[1], ovf[1], udf[1]);
        end
        step(0, 0, 1, 0, 0);
        vectors++;
        if (so[1] !== 12'h100) begin
            miscompares++;
            $display("FAIL replace_pop: got %h want 100", so[1]);
        end
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 12'h055, 0);
        vectors++;
        if (cnt[1] !== 4'd1 || so[1] !== 12'h055 || udf[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL pushpop_empty: got cnt=%0d out=%h u=%b, want 1 055 1", cnt[1], so[1], udf[1]);
        end
        for (int i = 1; i < 8; i++) step(0, 1, 0, 12'h300 + 12'(i), 0);
        step(0, 1, 1, 12'h3FF, 0);
        vectors++;
        if (cnt[0] !== 4'd8 || so[0] !== 12'h3FF || ovf[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL replace_full: got cnt=%0d out=%h o=%b, want 8 3ff 0", cnt[0], so[0], ovf[0]);
        end
    endtask

    task automatic test_reset_push();
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 12'h0A0 + 12'(i), 0);
        step(1, 1, 0, 12'h0FF, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({cnt[k], emp[k], ovf[k], udf[k], so[k]} !== {4'd0, 1'b1, 1'b0, 1'b0, 12'h000}) begin
                miscompares++;
                $display("FAIL reset_push dut%0d: got cnt=%0d e=%b o=%b u=%b out=%h, want 0 1 0 0 000",
                         k, cnt[k], emp[k], ovf[k], udf[k], so[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            bit rs, ps, pp, ce;
            rs = $urandom_range(0, 99) == 0;
            ps = $urandom_range(0, 99) < 55;
            pp = $urandom_range(0, 99) < 45;
            ce = $urandom_range(0, 15) == 0;
            step(rs, ps, pp, 12'($urandom), ce);
            for (int k = 0; k < 2; k++) begin
                logic [3:0] c;
                c = 4'(mq[k].size());
                vectors++;
                if (so[k] !== exp_top(k) || cnt[k] !== c || emp[k] !== (c == 0) || ful[k] !== (c == 8) ||
                    ovf[k] !== mo[k] || udf[k] !== mu[k]) begin
                    miscompares++;
                    $display("FAIL random%0d dut%0d: got out=%h cnt=%0d e=%b f=%b o=%b u=%b, want %h %0d %b %b %b %b",
                             n, k, so[k], cnt[k], emp[k], ful[k], ovf[k], udf[k],
                             exp_top(k), c, c == 0, c == 8, mo[k], mu[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_fill();
        test_underflow();
        test_back_to_back();
        test_reset_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
